tt_io_loopback_bist: RTL and testbench
======================================

# tt_io_loopback_bist

Built-in self-test engine for the Tiny Tapeout pad ring. It drives parametrised pattern sequences onto the dedicated user outputs and the bidirectional user IOs. It then checks the values returned through an external or harness loopback, with a configurable round-trip latency and an output-enable-aware expectation. It sits beside `tt_top` in on-silicon bring-up and in formal/simulation loopback harnesses, and reports a per-bit sticky error mask and a saturating mismatch count.

## Interface

- `N_O`, 8, dedicated output width (1..16)
- `N_IO`, 8, bidirectional IO width (1..16)
- `N_I`, 10, dedicated input width; must satisfy N_I >= N_O
- `LAT`, 0, round-trip cycles from drive to valid sample (0..7)
- `N_ITER`, 256, vectors per phase (2..65535)

Ports:

- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `mode`  in  2  0 walking-one, 1 walking-zero, 2 LFSR, 3 checkerboard
- `uo_out`  out  N_O  dedicated output pattern
- `uio_out`  out  N_IO  bidirectional output pattern
- `uio_oe`  out  N_IO  output enable, 1 = pin drives
- `ui_in`  in  N_I  dedicated inputs; bits [N_O-1:0] carry the loopback of `uo_out`
- `uio_in`  in  N_IO  bidirectional inputs; loopback is `uio_out & uio_oe`
- `busy`  out  1  run in progress
- `done`  out  1  run finished; level, held until next accepted start
- `pass`  out  1  `done && err_cnt == 0`
- `err_cnt`  out  16  mismatching vectors, saturates at 16'hFFFF
- `err_mask`  out  N_O+N_IO  sticky OR of mismatching bits; [N_O-1:0] uo, [N_O+N_IO-1:N_O] uio

## Operation

- States: IDLE, PH_A, PH_B, DONE.
- IDLE → PH_A when `start` is high. PH_A → PH_B after N_ITER vectors. PH_B → DONE after N_ITER vectors. DONE → PH_A on `start`.
- On an accepted start: `err_cnt`, `err_mask`, `done` and the vector index k clear, the LFSR reloads, and `mode` is latched for the whole run.
- `start` in PH_A or PH_B is ignored. `mode` changes mid-run are ignored.
- PH_A: `uio_oe` is all ones. Expected `uio_in` = uio pattern.
- PH_B: `uio_oe` is all zeros and `uio_out` still carries the pattern. Expected `uio_in` = 0.
- Both phases: expected `ui_in[N_O-1:0]` = uo pattern. `ui_in[N_I-1:N_O]` is never checked.
- Patterns for vector k (k restarts at 0 in each phase):
  - mode 0: uo = 1<<(k mod N_O), uio = 1<<(k mod N_IO)
  - mode 1: bitwise inverse of mode 0
  - mode 2: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, seed 16'hACE1, advanced once per vector. uo = lfsr[N_O-1:0], uio = lfsr[15:16-N_IO]. Vector 0 uses the seed. The LFSR is not reseeded at PH_B.
  - mode 3: 0x55… for even k, 0xAA… for odd k, truncated to width.
- Each vector is held for LAT+1 cycles. The compare happens on the last of those cycles.
- On a mismatch: `err_cnt` increments (saturating at 16'hFFFF) and `err_mask` ORs in the XOR of expected and actual.
- IDLE/DONE outputs: `uo_out` = 0, `uio_out` = 0, `uio_oe` = 0.
- `rst` from any state, including mid-run, forces IDLE with all outputs 0 on the next edge: `busy`, `done`, `pass`, `err_cnt`, `err_mask`, `uo_out`, `uio_out`, `uio_oe`.

## Timing

- `start` high at edge t (IDLE) → `busy` = 1 and vector 0 driven from t+1.
- Run length: 2·N_ITER·(LAT+1) cycles of `busy`.
- The final compare and its `err_cnt`/`err_mask` update take effect at the same edge that sets `done` = 1 and `busy` = 0.
- `busy` and `done` are never high together.
- `pass` is combinational from registered state and is never high while `busy`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

- Ideal zero-delay loopback, LAT=0, N_ITER=16, mode 0 → `busy` for exactly 32 cycles, then `done` = 1, `pass` = 1, `err_cnt` = 0, `err_mask` = 0.
- Same setup with `ui_in[3]` stuck at 0 → `err_cnt` = 4 (k = 3, 11 in each phase), `err_mask` = 1<<3, `pass` = 0.
- Same setup with `uio_in[2]` stuck at 1 → `err_cnt` = 30 (14 in PH_A + 16 in PH_B), `err_mask` = 1<<(N_O+2).
- Mode 2 → first driven vector is `uo_out` = 8'hE1, `uio_out` = 8'hAC, `uio_oe` = 8'hFF. Ideal loopback → `pass` = 1.
- LAT=2 DUT with a 2-cycle delayed loopback model → `pass` = 1. The same model against an LAT=1 DUT → `err_cnt` > 0.
- Assert `rst` mid-PH_A → next cycle all outputs are 0 and state is IDLE. A following `start` runs to completion with `pass` = 1. A `start` pulse during `busy` does not change the run length.

Source files
------------

// File: rtl/tt_io_loopback_bist.sv
// tt_io_loopback_bist
// Pad-ring loopback self-test. The block drives pattern vectors onto uo_out
// and uio_out, then compares the looped-back ui_in/uio_in values.
// PH_A checks the uio pads with their outputs enabled. PH_B disables them, so
// uio_in is expected to read all zeros.
// Results are a per-bit sticky error mask and a saturating mismatch count.
module tt_io_loopback_bist #(
    parameter int N_O    = 8,
    parameter int N_IO   = 8,
    parameter int N_I    = 10,
    parameter int LAT    = 0,
    parameter int N_ITER = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic [N_O-1:0]        uo_out,
    output logic [N_IO-1:0]       uio_out,
    output logic [N_IO-1:0]       uio_oe,
    input  logic [N_I-1:0]        ui_in,
    input  logic [N_IO-1:0]       uio_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_cnt,
    output logic [N_O+N_IO-1:0]   err_mask
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PH_A = 2'd1,
        S_PH_B = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] K_LAST    = 16'(N_ITER - 1);
    localparam logic [2:0]  HOLD_LAST = 3'(LAT);
    localparam logic [3:0]  PO_LAST   = 4'(N_O - 1);
    localparam logic [3:0]  PIO_LAST  = 4'(N_IO - 1);

    // Pattern for the dedicated outputs; pos is k mod N_O, par is k mod 2.
    function automatic logic [N_O-1:0] f_uo_pat(input logic [1:0] md,
                                                input logic [3:0] pos,
                                                input logic       par,
                                                input logic [15:0] lf);
        logic [N_O-1:0] v;
        v = '0;
        case (md)
            2'd0:    v = N_O'(1'b1) << pos;
            2'd1:    v = ~(N_O'(1'b1) << pos);
            2'd2:    v = lf[N_O-1:0];
            2'd3:    v = par ? N_O'(16'hAAAA) : N_O'(16'h5555);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Pattern for the bidirectional outputs; LFSR mode takes the top bits.
    function automatic logic [N_IO-1:0] f_uio_pat(input logic [1:0] md,
                                                  input logic [3:0] pos,
                                                  input logic       par,
                                                  input logic [15:0] lf);
        logic [N_IO-1:0] v;
        v = '0;
        case (md)
            2'd0:    v = N_IO'(1'b1) << pos;
            2'd1:    v = ~(N_IO'(1'b1) << pos);
            2'd2:    v = lf[15:16-N_IO];
            2'd3:    v = par ? N_IO'(16'hAAAA) : N_IO'(16'h5555);
            default: v = '0;
        endcase
        return v;
    endfunction

    state_t              r_state;
    logic [1:0]          r_mode;
    logic [15:0]         r_k;
    logic [2:0]          r_hold;
    logic [3:0]          r_pos_o;
    logic [3:0]          r_pos_io;
    logic                r_par;
    logic [15:0]         r_lfsr;
    logic [N_O-1:0]      r_uo;
    logic [N_IO-1:0]     r_uio;
    logic [N_IO-1:0]     r_oe;
    logic                r_busy;
    logic                r_done;
    logic [15:0]         r_err_cnt;
    logic [N_O+N_IO-1:0] r_err_mask;

    logic                w_last_hold;
    logic                w_last_vec;
    logic                w_idle_like;
    logic [15:0]         w_lfsr_adv;
    logic [3:0]          w_nv_pos_o;
    logic [3:0]          w_nv_pos_io;
    logic                w_nv_par;
    logic [15:0]         w_nv_lfsr;
    logic [1:0]          w_nv_mode;
    logic [N_O-1:0]      w_nv_uo;
    logic [N_IO-1:0]     w_nv_uio;
    logic [N_IO-1:0]     w_exp_uio;
    logic [N_O+N_IO-1:0] w_diff;
    logic                w_unused_ui;

    // The ui_in bits above the uo loopback are never compared.
    assign w_unused_ui = &{1'b0, ui_in};

    // Vector sequencing flags and the compare result for the current vector.
    always_comb begin
        w_last_hold = (r_hold == HOLD_LAST);
        w_last_vec  = (r_k == K_LAST);
        w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
        w_lfsr_adv  = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        if (r_state == S_PH_A) begin
            w_exp_uio = r_uio;
        end else begin
            w_exp_uio = '0;
        end
        w_diff = {uio_in ^ w_exp_uio, ui_in[N_O-1:0] ^ r_uo};
    end

    // Index state and pattern of the next vector to drive.
    always_comb begin
        w_nv_pos_o  = 4'd0;
        w_nv_pos_io = 4'd0;
        w_nv_par    = 1'b0;
        w_nv_lfsr   = LFSR_SEED;
        w_nv_mode   = r_mode;
        if (w_idle_like) begin
            // A new run begins from vector 0 with the mode presented now.
            w_nv_mode = mode;
        end else if (w_last_vec) begin
            // Phase boundary: k restarts, but the LFSR keeps running.
            w_nv_lfsr = w_lfsr_adv;
        end else begin
            w_nv_pos_o  = (r_pos_o == PO_LAST) ? 4'd0 : r_pos_o + 4'd1;
            w_nv_pos_io = (r_pos_io == PIO_LAST) ? 4'd0 : r_pos_io + 4'd1;
            w_nv_par    = ~r_par;
            w_nv_lfsr   = w_lfsr_adv;
        end
        w_nv_uo  = f_uo_pat(w_nv_mode, w_nv_pos_o, w_nv_par, w_nv_lfsr);
        w_nv_uio = f_uio_pat(w_nv_mode, w_nv_pos_io, w_nv_par, w_nv_lfsr);
    end

    // Run controller: phase sequencing, pattern drive and error accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= 2'd0;
            r_k        <= 16'd0;
            r_hold     <= 3'd0;
            r_pos_o    <= 4'd0;
            r_pos_io   <= 4'd0;
            r_par      <= 1'b0;
            r_lfsr     <= LFSR_SEED;
            r_uo       <= '0;
            r_uio      <= '0;
            r_oe       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err_cnt  <= 16'd0;
            r_err_mask <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_PH_A;
                        r_mode     <= mode;
                        r_k        <= 16'd0;
                        r_hold     <= 3'd0;
                        r_pos_o    <= w_nv_pos_o;
                        r_pos_io   <= w_nv_pos_io;
                        r_par      <= w_nv_par;
                        r_lfsr     <= w_nv_lfsr;
                        r_uo       <= w_nv_uo;
                        r_uio      <= w_nv_uio;
                        r_oe       <= '1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err_cnt  <= 16'd0;
                        r_err_mask <= '0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_PH_A, S_PH_B: begin
                    if (!w_last_hold) begin
                        r_hold <= r_hold + 3'd1;
                    end else begin
                        r_hold <= 3'd0;
                        if (|w_diff) begin
                            if (r_err_cnt != 16'hFFFF) begin
                                r_err_cnt <= r_err_cnt + 16'd1;
                            end
                            r_err_mask <= r_err_mask | w_diff;
                        end
                        if (w_last_vec && (r_state == S_PH_B)) begin
                            r_state <= S_DONE;
                            r_k     <= 16'd0;
                            r_uo    <= '0;
                            r_uio   <= '0;
                            r_oe    <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_pos_o  <= w_nv_pos_o;
                            r_pos_io <= w_nv_pos_io;
                            r_par    <= w_nv_par;
                            r_lfsr   <= w_nv_lfsr;
                            r_uo     <= w_nv_uo;
                            r_uio    <= w_nv_uio;
                            if (w_last_vec) begin
                                // PH_A -> PH_B: release the uio pads.
                                r_state <= S_PH_B;
                                r_k     <= 16'd0;
                                r_oe    <= '0;
                            end else begin
                                r_k <= r_k + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_uo    <= '0;
                    r_uio   <= '0;
                    r_oe    <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out   = r_uo;
    assign uio_out  = r_uio;
    assign uio_oe   = r_oe;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_done && (r_err_cnt == 16'd0);
    assign err_cnt  = r_err_cnt;
    assign err_mask = r_err_mask;

endmodule

// File: tb/tb_tt_io_loopback_bist.sv
// Bench for tt_io_loopback_bist: an ideal loopback with stuck-at faults on an
// LAT=0 instance, plus a 2-cycle delayed loopback on LAT=2 and LAT=1 instances.
module tb_tt_io_loopback_bist;

    localparam int NIT   = 16;
    localparam int NIT_D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     = 1'b1;
    logic       start   = 1'b0;
    logic [1:0] mode    = 2'd0;
    logic       start_d = 1'b0;
    logic [1:0] mode_d  = 2'd0;

    // Fault injection on the main loopback: actual = (ideal & and) | or.
    logic [7:0] ui_and  = 8'hFF;
    logic [7:0] ui_or   = 8'h00;
    logic [7:0] uio_and = 8'hFF;
    logic [7:0] uio_or  = 8'h00;

    logic [7:0]  m_uo, m_uio, m_oe, m_uioin;
    logic [9:0]  m_ui;
    logic        m_busy, m_done, m_pass;
    logic [15:0] m_err, m_mask;

    assign m_ui    = {2'b10, (m_uo & ui_and) | ui_or};
    assign m_uioin = ((m_uio & m_oe) & uio_and) | uio_or;

    tt_io_loopback_bist #(.N_O(8), .N_IO(8), .N_I(10), .LAT(0), .N_ITER(NIT)) u_main (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .uo_out(m_uo), .uio_out(m_uio), .uio_oe(m_oe),
        .ui_in(m_ui), .uio_in(m_uioin),
        .busy(m_busy), .done(m_done), .pass(m_pass),
        .err_cnt(m_err), .err_mask(m_mask)
    );

    // Two instances sharing a 2-cycle delayed loopback model.
    logic [7:0]  d2_uo, d2_uio, d2_oe, d2_q1, d2_q2, d2_v1, d2_v2;
    logic [7:0]  d1_uo, d1_uio, d1_oe, d1_q1, d1_q2, d1_v1, d1_v2;
    logic        d2_busy, d2_done, d2_pass, d1_busy, d1_done, d1_pass;
    logic [15:0] d2_err, d2_mask, d1_err, d1_mask;

    always @(posedge clk) begin
        d2_q1 <= d2_uo;          d2_q2 <= d2_q1;
        d2_v1 <= d2_uio & d2_oe; d2_v2 <= d2_v1;
        d1_q1 <= d1_uo;          d1_q2 <= d1_q1;
        d1_v1 <= d1_uio & d1_oe; d1_v2 <= d1_v1;
    end

    tt_io_loopback_bist #(.N_O(8), .N_IO(8), .N_I(10), .LAT(2), .N_ITER(NIT_D)) u_lat2 (
        .clk(clk), .rst(rst), .start(start_d), .mode(mode_d),
        .uo_out(d2_uo), .uio_out(d2_uio), .uio_oe(d2_oe),
        .ui_in({2'b00, d2_q2}), .uio_in(d2_v2),
        .busy(d2_busy), .done(d2_done), .pass(d2_pass),
        .err_cnt(d2_err), .err_mask(d2_mask)
    );

    tt_io_loopback_bist #(.N_O(8), .N_IO(8), .N_I(10), .LAT(1), .N_ITER(NIT_D)) u_lat1 (
        .clk(clk), .rst(rst), .start(start_d), .mode(mode_d),
        .uo_out(d1_uo), .uio_out(d1_uio), .uio_oe(d1_oe),
        .ui_in({2'b00, d1_q2}), .uio_in(d1_v2),
        .busy(d1_busy), .done(d1_done), .pass(d1_pass),
        .err_cnt(d1_err), .err_mask(d1_mask)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: expected vectors per phase/k and expected error totals.
    logic [7:0]  e_uo  [0:1][0:NIT-1];
    logic [7:0]  e_uio [0:1][0:NIT-1];
    int          exp_cnt;
    logic [15:0] exp_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int v;
        int fb;
        v  = int'(s);
        fb = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 16'((v >> 1) | (fb << 15));
    endfunction

    task automatic build_model(input int md);
        logic [15:0] lf;
        logic [7:0]  act_uo, exp_uio, act_uio;
        logic [15:0] x;
        lf = 16'hACE1;
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < NIT; k++) begin
                case (md)
                    0: begin
                        e_uo[ph][k]  = 8'(1 << (k % 8));
                        e_uio[ph][k] = 8'(1 << (k % 8));
                    end
                    1: begin
                        e_uo[ph][k]  = ~8'(1 << (k % 8));
                        e_uio[ph][k] = ~8'(1 << (k % 8));
                    end
                    2: begin
                        e_uo[ph][k]  = lf[7:0];
                        e_uio[ph][k] = lf[15:8];
                    end
                    default: begin
                        e_uo[ph][k]  = (k % 2 == 0) ? 8'h55 : 8'hAA;
                        e_uio[ph][k] = (k % 2 == 0) ? 8'h55 : 8'hAA;
                    end
                endcase
                lf = lfsr_next(lf);
            end
        end
        exp_cnt  = 0;
        exp_mask = 16'h0000;
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < NIT; k++) begin
                act_uo  = (e_uo[ph][k] & ui_and) | ui_or;
                exp_uio = (ph == 0) ? e_uio[ph][k] : 8'h00;
                act_uio = (exp_uio & uio_and) | uio_or;
                x = {exp_uio ^ act_uio, e_uo[ph][k] ^ act_uo};
                if (x != 16'h0000) begin
                    exp_cnt++;
                    exp_mask = exp_mask | x;
                end
            end
        end
    endtask

    // One full run on the main instance, checking every cycle's drive.
    task automatic run_main(input int md, input bit inject);
        build_model(md);
        @(negedge clk);
        mode  = 2'(md);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2 * NIT; c++) begin
            int ph;
            int k;
            ph = c / NIT;
            k  = c % NIT;
            chk($sformatf("vec_m%0d_c%0d", md, c),
                {6'd0, m_busy, m_done, m_uo, m_uio, m_oe},
                {6'd0, 1'b1, 1'b0, e_uo[ph][k], e_uio[ph][k], (ph == 0) ? 8'hFF : 8'h00});
            if (md == 2 && c == 0) chk("m2_first_vec", {8'd0, m_uo, m_uio, m_oe}, 32'h00E1ACFF);
            if (inject && c == 5) begin
                start = 1'b1;
                mode  = ~mode;
            end
            if (inject && c == 6) start = 1'b0;
            @(negedge clk);
        end
        chk($sformatf("end_flags_m%0d", md),
            {5'd0, m_busy, m_done, m_pass, m_uo, m_uio, m_oe},
            {5'd0, 1'b0, 1'b1, (exp_cnt == 0), 8'h00, 8'h00, 8'h00});
        chk($sformatf("err_cnt_m%0d", md), {16'd0, m_err}, 32'(exp_cnt));
        chk($sformatf("err_mask_m%0d", md), {16'd0, m_mask}, {16'd0, exp_mask});
    endtask

    task automatic clear_faults();
        ui_and  = 8'hFF;
        ui_or   = 8'h00;
        uio_and = 8'hFF;
        uio_or  = 8'h00;
    endtask

    initial begin
        int cnt2;
        int cnt1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {5'd0, m_busy, m_done, m_pass, m_uo, m_uio, m_oe}, 32'd0);
        chk("reset_err", {m_err, m_mask}, 32'd0);
        rst = 1'b0;

        // Ideal loopback, walking one; done must stay high afterwards.
        run_main(0, 1'b0);
        repeat (3) @(negedge clk);
        chk("done_held", {30'd0, m_busy, m_done}, 32'd1);

        // ui_in[3] stuck at 0.
        ui_and = 8'hF7;
        run_main(0, 1'b0);
        chk("tp_ui3_cnt", {16'd0, m_err}, 32'd4);
        chk("tp_ui3_mask", {16'd0, m_mask}, 32'h0008);
        clear_faults();

        // uio_in[2] stuck at 1.
        uio_or = 8'h04;
        run_main(0, 1'b0);
        chk("tp_uio2_cnt", {16'd0, m_err}, 32'd30);
        chk("tp_uio2_mask", {16'd0, m_mask}, 32'h0400);
        clear_faults();

        // LFSR mode, then start/mode disturbances mid-run.
        run_main(2, 1'b0);
        run_main(3, 1'b1);
        run_main(1, 1'b1);

        // Reset mid-PH_A after one error has been recorded.
        ui_and = 8'hF7;
        @(negedge clk);
        mode  = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_state", {15'd0, m_busy, m_err}, {15'd0, 1'b1, 16'd1});
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_outputs", {5'd0, m_busy, m_done, m_pass, m_uo, m_uio, m_oe}, 32'd0);
        chk("midrun_rst_err", {m_err, m_mask}, 32'd0);
        rst = 1'b0;
        clear_faults();
        run_main(0, 1'b0);

        // Randomized modes and faults.
        for (int r = 0; r < 6; r++) begin
            int md;
            int kind;
            int b;
            md   = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 3));
            b    = int'($urandom_range(0, 7));
            case (kind)
                1: ui_and = ~8'(1 << b);
                2: uio_or = 8'(1 << b);
                3: begin
                    ui_or   = 8'($urandom_range(0, 255));
                    uio_and = 8'($urandom_range(0, 255));
                end
                default: clear_faults();
            endcase
            run_main(md, 1'b0);
            clear_faults();
        end

        // Delayed loopback: LAT=2 matches it, LAT=1 does not.
        @(negedge clk);
        mode_d  = 2'($urandom_range(0, 3));
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        cnt2 = 0;
        cnt1 = 0;
        for (int i = 0; i < 200 && !(d2_done && d1_done); i++) begin
            if (d2_busy) cnt2++;
            if (d1_busy) cnt1++;
            @(negedge clk);
        end
        chk("delay_done_in_time", {30'd0, d2_done, d1_done}, 32'd3);
        chk("lat2_busy_cycles", 32'(cnt2), 32'd48);
        chk("lat1_busy_cycles", 32'(cnt1), 32'd32);
        chk("lat2_pass", {15'd0, d2_pass, d2_err}, {15'd0, 1'b1, 16'd0});
        chk("lat1_err_nonzero", {31'd0, (d1_err != 16'd0)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
